// File: rtl/grf_scoreboard.sv
// ID-stage register file with NREAD combinational read ports, one W-stage write port and a
// per-register pending-write counter. Optional write-through bypass: define GRF_BYPASS_EN.
module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int CNT_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREAD*ADDR_W-1:0]   rd_addr,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  output logic [NREAD-1:0]          rd_busy,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      iss_en,
  input  logic [ADDR_W-1:0]         iss_addr,
  input  logic                      flush,
  output logic                      ovf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q [DEPTH];
  logic [CNT_W-1:0]  cnt_d [DEPTH];
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  iss_hit;
  logic              ovf_q;
  logic              ovf_d;
  logic              iss_nz;
  logic              iss_wr_same;

  // One-hot decode of the write and issue targets; register 0 never matches.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_decode
      if (gi == 0) begin : g_zero
        assign wr_hit[gi]  = 1'b0;
        assign iss_hit[gi] = 1'b0;
      end else begin : g_nonzero
        assign wr_hit[gi]  = wr_en  && (wr_addr  == ADDR_W'(gi));
        assign iss_hit[gi] = iss_en && (iss_addr == ADDR_W'(gi));
      end
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (k == 0) begin
        cnt_d[k] = '0;
      end else if (flush) begin
        cnt_d[k] = '0;
      end else if (iss_hit[k] && wr_hit[k]) begin
        cnt_d[k] = cnt_q[k];
      end else if (iss_hit[k]) begin
        if (cnt_q[k] != CNT_MAX) begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end else if (wr_hit[k]) begin
        if (cnt_q[k] != '0) begin
          cnt_d[k] = cnt_q[k] - CNT_W'(1);
        end
      end
    end
  end

  // A saturated issue is only "dropped" when no same-address write cancels it and no flush wins.
  assign iss_nz      = iss_en && (iss_addr != '0);
  assign iss_wr_same = wr_en && (wr_addr == iss_addr);

  always_comb begin
    ovf_d = ovf_q;
    if (iss_nz && !flush && !iss_wr_same && (cnt_q[iss_addr] == CNT_MAX)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        if (wr_hit[k]) begin
          mem_q[k] <= wr_data;
        end
        cnt_q[k] <= cnt_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;

  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_read
      logic [ADDR_W-1:0] ra;
      logic              ra_nz;
      logic [CNT_W-1:0]  ra_cnt;
      logic              ra_wr;
      logic              ra_iss;

      assign ra     = rd_addr[gi*ADDR_W +: ADDR_W];
      assign ra_nz  = (ra != '0);
      assign ra_cnt = cnt_q[ra];
      assign ra_wr  = wr_en && (wr_addr == ra) && ra_nz;
      assign ra_iss = iss_en && (iss_addr == ra);

`ifdef GRF_BYPASS_EN
      // Write-through: a same-cycle W write is visible now and retires one pending producer,
      // unless an issue to the same register re-arms it. Suppressed while held in reset.
      logic byp;
      assign byp = reset && ra_wr;

      assign rd_data[gi*DATA_W +: DATA_W] = !ra_nz ? '0 :
                                            byp    ? wr_data : mem_q[ra];
      assign rd_busy[gi] = ra_nz && ((byp && !ra_iss) ? (ra_cnt > CNT_W'(1))
                                                      : (ra_cnt != '0));
`else
      logic unused_ra;
      assign unused_ra = ra_wr ^ ra_iss;

      assign rd_data[gi*DATA_W +: DATA_W] = ra_nz ? mem_q[ra] : '0;
      assign rd_busy[gi] = ra_nz && (ra_cnt != '0);
`endif
    end
  endgenerate

endmodule

// File: tb/tb_grf_scoreboard.sv
// Scoreboard bench for grf_scoreboard: driver pushes expected read-port state per cycle,
// a negedge monitor pops and compares. Expectations follow GRF_BYPASS_EN when defined.
module tb_grf_scoreboard;

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        flush;
  logic        ovf;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .CNT_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so the value for the cycle's inputs is settled by negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (rd_data[31:0] !== e.d0 || rd_data[63:32] !== e.d1 || rd_busy !== e.busy || ovf !== e.ovf) begin
        n_fail++;
        $display("[TB] FAIL %s: got d0=%h d1=%h busy=%b ovf=%b, want d0=%h d1=%h busy=%b ovf=%b",
                 e.name, rd_data[31:0], rd_data[63:32], rd_busy, ovf, e.d0, e.d1, e.busy, e.ovf);
      end else begin
        $display("[TB] ok   %s: d0=%h d1=%h busy=%b ovf=%b", e.name, e.d0, e.d1, e.busy, e.ovf);
      end
    end
  end

  task automatic step(input string nm,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ie, input logic [4:0] ia, input logic fl,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input logic [1:0] eb, input logic eo);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; flush = fl;
    rd_addr = {a1, a0};
    e.name = nm; e.d0 = e0; e.d1 = e1; e.busy = eb; e.ovf = eo;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0; rd_addr = '0;
    @(posedge clk);
    #1;

    // Reset held: writes/issues must not be visible.
    step("rst_wr",   1, 5'd5, 32'h1234,     0, 0,    0, 5'd5, 5'd0, 0, 0, 2'b00, 0);
    step("rst_iss",  1, 5'd5, 32'h1234,     1, 5'd5, 0, 5'd5, 5'd5, 0, 0, 2'b00, 0);
    reset = 1'b1;
    step("rst_rel",  0, 0, 0,               0, 0,    0, 5'd5, 5'd5, 0, 0, 2'b00, 0);

    // Basic write/read and r0 behaviour.
    step("wr_r3",    1, 5'd3, 32'hDEADBEEF, 0, 0,    0, 5'd0, 5'd0, 0, 0, 2'b00, 0);
    step("wr_r0",    1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 0, 5'd3, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
    step("rd_r0",    0, 0, 0,               0, 0,    0, 5'd0, 5'd3, 0, 32'hDEADBEEF, 2'b00, 0);

    // Scoreboard on r7.
    step("iss_r7a",  0, 0, 0,               1, 5'd7, 0, 5'd7, 5'd3, 0, 32'hDEADBEEF, 2'b00, 0);
    step("iss_r7b",  0, 0, 0,               1, 5'd7, 0, 5'd7, 5'd0, 0, 0, 2'b01, 0);
    step("wr_r7a",   1, 5'd7, 32'h77,       0, 0,    0, 5'd3, 5'd0, 32'hDEADBEEF, 0, 2'b00, 0);
    step("rd_r7c1",  0, 0, 0,               0, 0,    0, 5'd7, 5'd7, 32'h77, 32'h77, 2'b11, 0);
    step("wr_r7b",   1, 5'd7, 32'h78,       0, 0,    0, 5'd0, 5'd0, 0, 0, 2'b00, 0);
    step("rd_r7c0",  0, 0, 0,               0, 0,    0, 5'd7, 5'd0, 32'h78, 0, 2'b00, 0);
    step("wr_r7uf",  1, 5'd7, 32'h79,       0, 0,    0, 5'd0, 5'd0, 0, 0, 2'b00, 0);
    step("rd_r7uf",  0, 0, 0,               0, 0,    0, 5'd7, 5'd0, 32'h79, 0, 2'b00, 0);

    // Saturation on r9 (max 3).
    step("iss_r9a",  0, 0, 0,               1, 5'd9, 0, 5'd0, 5'd0, 0, 0, 2'b00, 0);
    step("iss_r9b",  0, 0, 0,               1, 5'd9, 0, 5'd0, 5'd0, 0, 0, 2'b00, 0);
    step("iss_r9c",  0, 0, 0,               1, 5'd9, 0, 5'd0, 5'd0, 0, 0, 2'b00, 0);
    step("isswr_r9", 1, 5'd9, 32'h99,       1, 5'd9, 0, 5'd0, 5'd0, 0, 0, 2'b00, 0);
    step("rd_r9max", 0, 0, 0,               0, 0,    0, 5'd9, 5'd0, 32'h99, 0, 2'b01, 0);
    step("iss_r9ov", 0, 0, 0,               1, 5'd9, 0, 5'd9, 5'd0, 32'h99, 0, 2'b01, 0);
    step("ovf_set",  0, 0, 0,               0, 0,    0, 5'd9, 5'd0, 32'h99, 0, 2'b01, 1);
    step("wr_r9",    1, 5'd9, 32'h9A,       0, 0,    0, 5'd0, 5'd0, 0, 0, 2'b00, 1);
    step("rd_r9c2",  0, 0, 0,               0, 0,    0, 5'd9, 5'd0, 32'h9A, 0, 2'b01, 1);

    // Flush with same-cycle issue and write.
    step("iss_r1a",  0, 0, 0,               1, 5'd1, 0, 5'd0, 5'd0, 0, 0, 2'b00, 1);
    step("iss_r1b",  0, 0, 0,               1, 5'd1, 0, 5'd0, 5'd0, 0, 0, 2'b00, 1);
    step("iss_r2",   0, 0, 0,               1, 5'd2, 0, 5'd0, 5'd0, 0, 0, 2'b00, 1);
    step("rd_r1r2",  0, 0, 0,               0, 0,    0, 5'd1, 5'd2, 0, 0, 2'b11, 1);
    step("flush",    1, 5'd1, 32'h55,       1, 5'd4, 1, 5'd0, 5'd0, 0, 0, 2'b00, 1);
    step("rd_fl_a",  0, 0, 0,               0, 0,    0, 5'd1, 5'd2, 32'h55, 0, 2'b00, 1);
    step("rd_fl_b",  0, 0, 0,               0, 0,    0, 5'd4, 5'd9, 0, 32'h9A, 2'b00, 1);

    // Bypass behaviour on r6 with one producer in flight.
    step("wr_r6",    1, 5'd6, 32'h11,       0, 0,    0, 5'd0, 5'd0, 0, 0, 2'b00, 1);
    step("iss_r6",   0, 0, 0,               1, 5'd6, 0, 5'd0, 5'd0, 0, 0, 2'b00, 1);
`ifdef GRF_BYPASS_EN
    step("byp_r6",   1, 5'd6, 32'h22,       0, 0,    0, 5'd6, 5'd0, 32'h22, 0, 2'b00, 1);
`else
    step("byp_r6",   1, 5'd6, 32'h22,       0, 0,    0, 5'd6, 5'd0, 32'h11, 0, 2'b01, 1);
`endif
    step("rd_r6",    0, 0, 0,               0, 0,    0, 5'd6, 5'd6, 32'h22, 32'h22, 2'b00, 1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("[TB] FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Parametrised general register file for the ID stage, with NREAD read ports and one writeback (W-stage) write port.
- Each register carries a pending-write counter (scoreboard), so the ID-stage hazard logic can see whether a source register still has producers in flight.
- Generalises the fixed 2-read/32x32 register file: depth, width and read-port count are parameters, with per-register in-flight tracking, flush and overflow reporting.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NREAD, 2, number of combinational read ports.
- CNT_W, 2, width of each pending-write counter; max in-flight per register = 2**CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- rd_addr  in  NREAD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  NREAD*DATA_W  packed read data, combinational.
- rd_busy  out  NREAD  1 when the addressed register has a pending-write count != 0.
- wr_en  in  1  W-stage write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- iss_en  in  1  an instruction writing iss_addr leaves ID this cycle.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- flush  in  1  synchronous clear of all pending counters; registers unaffected.
- ovf  out  1  sticky: an issue was dropped because its counter was saturated.

Behaviour:
Reset:
- reset=0 asynchronously clears all registers, all counters and ovf to 0.
- rd_data and rd_busy follow combinationally, so they read 0 during reset.

Register 0:
- Reads always return 0 with rd_busy=0.
- Writes to address 0 are discarded.
- Issues to address 0 are ignored: no count change, no overflow.

Write (posedge, wr_en=1, wr_addr!=0):
- mem[wr_addr] <= wr_data.
- Counter of wr_addr decrements by 1 if nonzero.
- If the counter is already 0, the write still occurs and the counter stays 0 (no underflow).

Issue (posedge, iss_en=1, iss_addr!=0):
- Counter of iss_addr increments by 1.
- If the counter is at max, it holds and ovf <= 1.
- ovf clears only on reset.

Same cycle, both events on the same nonzero address:
- Counter unchanged (+1 and -1 cancel), including at max; no overflow in that case.
- Data is written.

Flush (posedge):
- All counters <= 0; takes priority over same-cycle issue and decrement.
- The write data is still committed.

Reads:
- Purely combinational from the stored state.
- All NREAD ports are independent; any may alias any other or the write address.

Widths:
- Counters wrap never; they saturate at both ends.
- Addresses beyond depth cannot occur.

Optional Feature:
- Macro GRF_BYPASS_EN.
- Defined: when wr_en=1 and wr_addr==rd_addr[i]!=0, rd_data[i]=wr_data in the same cycle (write-through). rd_busy[i] is computed from the count after the pending decrement, i.e. it is 0 if the current count is 1 and no same-address issue occurs.
- Undefined: reads return the pre-edge stored value, and rd_busy reflects the current count only. The hazard unit must then forward from W externally.

Test Plan:
- Reset: hold reset=0, write r5=0x1234 -> all rd_data=0, rd_busy=0, ovf=0; after release, r5 reads 0.
- Basic write/read: wr r3=0xDEADBEEF, next cycle rd_addr0=3, rd_addr1=3 -> both 0xDEADBEEF, busy 0. Write r0=0xFFFFFFFF -> r0 reads 0.
- Scoreboard: issue r7 twice (count 2) -> busy=1; one write -> busy=1; second write -> busy=0. Write r7 with count 0 -> count stays 0.
- Simultaneous and saturation: issue r9 x3 (CNT_W=2, max 3), then issue+write r9 same cycle -> count 3, ovf=0. Fourth plain issue -> count 3, ovf=1 and sticky.
- Flush: counts r1=2, r2=1; flush with same-cycle iss r4 and wr r1=0x55 -> all busy 0, r1 reads 0x55.
- Bypass (GRF_BYPASS_EN): r6=0x11, count 1; wr r6=0x22 with rd_addr0=6 -> same cycle rd_data0=0x22, busy0=0. Without the macro -> 0x11, busy0=1.
